// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART configuration-command parser:
// FSM encoding, rejection codes, default frame markers and the checksum step.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHAN   = 3'd1,
      ST_ADDER  = 3'd2,
      ST_AMPL   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_EOM    = 3'd5,
      ST_COMMIT = 3'd6
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_EOM     = 3'd1;
   localparam logic [2:0] ERR_CSUM    = 3'd2;
   localparam logic [2:0] ERR_CHAN    = 3'd3;
   localparam logic [2:0] ERR_LINE    = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT = 3'd5;

   localparam logic [7:0] DEFAULT_SOM = 8'd153;
   localparam logic [7:0] DEFAULT_EOM = 8'd235;

   function automatic logic [7:0] csum_step(input logic [7:0] i_acc, input logic [7:0] i_byte);
      return i_acc ^ i_byte;
   endfunction

endpackage

// File: rtl/uart_cmd_bank.sv
// Live per-channel DDS register bank; one write port, flattened outputs and
// a registered one-cycle update strobe on the written channel.
module uart_cmd_bank
   import uart_cmd_pkg::*;
#(
   parameter int          NUM_CHANNELS = 4,
   parameter int          ADDER_WIDTH  = 32,
   parameter int          AMPL_WIDTH   = 32,
   parameter logic [31:0] RESET_ADDER  = 32'd1000000,
   parameter logic [31:0] RESET_AMPL   = 32'd1000000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_wr_en,
   input  logic [7:0]                           i_wr_chan,
   input  logic [ADDER_WIDTH-1:0]               i_wr_adder,
   input  logic [AMPL_WIDTH-1:0]                i_wr_ampl,
   output logic [NUM_CHANNELS*ADDER_WIDTH-1:0]  o_adder_bus,
   output logic [NUM_CHANNELS*AMPL_WIDTH-1:0]   o_amplitude_bus,
   output logic [NUM_CHANNELS-1:0]              o_update_strobe
);

   logic [NUM_CHANNELS*ADDER_WIDTH-1:0] r_adder_bus;
   logic [NUM_CHANNELS*AMPL_WIDTH-1:0]  r_ampl_bus;
   logic [NUM_CHANNELS-1:0]             r_strobe;

   // bank storage and strobe, written only by a validated commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            r_adder_bus[k*ADDER_WIDTH +: ADDER_WIDTH] <= ADDER_WIDTH'(RESET_ADDER);
            r_ampl_bus[k*AMPL_WIDTH +: AMPL_WIDTH]    <= AMPL_WIDTH'(RESET_AMPL);
         end
         r_strobe <= {NUM_CHANNELS{1'b0}};
      end else begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (i_wr_en && (i_wr_chan == 8'(k))) begin
               r_adder_bus[k*ADDER_WIDTH +: ADDER_WIDTH] <= i_wr_adder;
               r_ampl_bus[k*AMPL_WIDTH +: AMPL_WIDTH]    <= i_wr_ampl;
               r_strobe[k]                               <= 1'b1;
            end else begin
               r_strobe[k] <= 1'b0;
            end
         end
      end
   end

   assign o_adder_bus     = r_adder_bus;
   assign o_amplitude_bus = r_ampl_bus;
   assign o_update_strobe = r_strobe;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SOM/channel/adder/amplitude/[checksum]/EOM frames from the UART RX
// byte stream and commits validated frames atomically into the channel bank.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int          NUM_CHANNELS   = 4,
   parameter int          ADDER_WIDTH    = 32,
   parameter int          AMPL_WIDTH     = 32,
   parameter logic [7:0]  SOM_BYTE       = DEFAULT_SOM,
   parameter logic [7:0]  EOM_BYTE       = DEFAULT_EOM,
   parameter bit          CHECKSUM_EN    = 1'b1,
   parameter int          TIMEOUT_CYCLES = 50000,
   parameter logic [31:0] RESET_ADDER    = 32'd1000000,
   parameter logic [31:0] RESET_AMPL     = 32'd1000000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [7:0]                           from_uart_data,
   input  logic                                 from_uart_valid,
   input  logic                                 from_uart_error,
   output logic                                 from_uart_ready,
   output logic [NUM_CHANNELS*ADDER_WIDTH-1:0]  adder_bus,
   output logic [NUM_CHANNELS*AMPL_WIDTH-1:0]   amplitude_bus,
   output logic [NUM_CHANNELS-1:0]              update_strobe,
   output logic                                 frame_error,
   output logic [2:0]                           error_code,
   output logic [15:0]                          error_count
);

   localparam int               ADDER_BYTES = ADDER_WIDTH / 8;
   localparam int               AMPL_BYTES  = AMPL_WIDTH / 8;
   localparam int               TMO_W       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0] TMO_HIT     = TMO_W'(TIMEOUT_CYCLES - 2);
   localparam logic [2:0]       ADDER_LAST  = 3'(ADDER_BYTES - 1);
   localparam logic [2:0]       AMPL_LAST   = 3'(AMPL_BYTES - 1);

   state_t                 r_state;
   logic [7:0]             r_chan;
   logic [7:0]             r_csum;
   logic [7:0]             r_rx_csum;
   logic [2:0]             r_cnt;
   logic [ADDER_WIDTH-1:0] r_adder_sh;
   logic [AMPL_WIDTH-1:0]  r_ampl_sh;
   logic [TMO_W-1:0]       r_tmo;
   logic                   r_wr_en;
   logic                   r_frame_error;
   logic [2:0]             r_error_code;
   logic [15:0]            r_error_count;

   logic                   w_accept;
   logic                   w_in_frame;
   logic                   w_reject;
   logic [2:0]             w_reject_code;

   assign from_uart_ready = (r_state != ST_COMMIT);
   assign w_accept        = from_uart_valid && from_uart_ready;
   assign w_in_frame      = (r_state != ST_IDLE) && (r_state != ST_COMMIT);

   // rejection decision; line error beats the EOM checks, timeout only on idle cycles
   always_comb begin
      w_reject      = 1'b0;
      w_reject_code = ERR_NONE;
      if (w_in_frame && w_accept && from_uart_error) begin
         w_reject      = 1'b1;
         w_reject_code = ERR_LINE;
      end else if (w_in_frame && w_accept && (r_state == ST_EOM)) begin
         if (from_uart_data != EOM_BYTE) begin
            w_reject      = 1'b1;
            w_reject_code = ERR_EOM;
         end else if (CHECKSUM_EN && (r_csum != r_rx_csum)) begin
            w_reject      = 1'b1;
            w_reject_code = ERR_CSUM;
         end else if ({1'b0, r_chan} >= 9'(NUM_CHANNELS)) begin
            w_reject      = 1'b1;
            w_reject_code = ERR_CHAN;
         end else begin
            w_reject      = 1'b0;
            w_reject_code = ERR_NONE;
         end
      end else if (w_in_frame && !w_accept && (r_tmo == TMO_HIT)) begin
         w_reject      = 1'b1;
         w_reject_code = ERR_TIMEOUT;
      end else begin
         w_reject      = 1'b0;
         w_reject_code = ERR_NONE;
      end
   end

   // frame FSM with shadow registers, timeout counter and error reporting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_chan        <= 8'd0;
         r_csum        <= 8'd0;
         r_rx_csum     <= 8'd0;
         r_cnt         <= 3'd0;
         r_adder_sh    <= {ADDER_WIDTH{1'b0}};
         r_ampl_sh     <= {AMPL_WIDTH{1'b0}};
         r_tmo         <= {TMO_W{1'b0}};
         r_wr_en       <= 1'b0;
         r_frame_error <= 1'b0;
         r_error_code  <= ERR_NONE;
         r_error_count <= 16'd0;
      end else begin
         r_frame_error <= 1'b0;
         r_wr_en       <= 1'b0;
         if (w_reject) begin
            r_state       <= ST_IDLE;
            r_tmo         <= {TMO_W{1'b0}};
            r_frame_error <= 1'b1;
            r_error_code  <= w_reject_code;
            if (r_error_count != 16'hFFFF) begin
               r_error_count <= r_error_count + 16'd1;
            end
         end else if (r_state == ST_COMMIT) begin
            // shadows stay stable until the next frame's adder bytes, so the bank reads them directly
            r_wr_en <= 1'b1;
            r_state <= ST_IDLE;
         end else if (w_accept) begin
            r_tmo <= {TMO_W{1'b0}};
            case (r_state)
               ST_IDLE: begin
                  if (!from_uart_error && (from_uart_data == SOM_BYTE)) begin
                     r_state <= ST_CHAN;
                  end
               end
               ST_CHAN: begin
                  r_chan  <= from_uart_data;
                  r_csum  <= from_uart_data;
                  r_cnt   <= 3'd0;
                  r_state <= ST_ADDER;
               end
               ST_ADDER: begin
                  r_adder_sh <= (r_adder_sh << 8) | ADDER_WIDTH'(from_uart_data);
                  r_csum     <= csum_step(r_csum, from_uart_data);
                  if (r_cnt == ADDER_LAST) begin
                     r_cnt   <= 3'd0;
                     r_state <= ST_AMPL;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
               ST_AMPL: begin
                  r_ampl_sh <= (r_ampl_sh << 8) | AMPL_WIDTH'(from_uart_data);
                  r_csum    <= csum_step(r_csum, from_uart_data);
                  if (r_cnt == AMPL_LAST) begin
                     r_cnt   <= 3'd0;
                     r_state <= CHECKSUM_EN ? ST_CSUM : ST_EOM;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
               ST_CSUM: begin
                  r_rx_csum <= from_uart_data;
                  r_state   <= ST_EOM;
               end
               ST_EOM: begin
                  r_state <= ST_COMMIT;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end else if (w_in_frame) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end else begin
            r_tmo <= {TMO_W{1'b0}};
         end
      end
   end

   uart_cmd_bank #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .ADDER_WIDTH  (ADDER_WIDTH),
      .AMPL_WIDTH   (AMPL_WIDTH),
      .RESET_ADDER  (RESET_ADDER),
      .RESET_AMPL   (RESET_AMPL)
   ) u_bank (
      .clk             (clk),
      .rst             (rst),
      .i_wr_en         (r_wr_en),
      .i_wr_chan       (r_chan),
      .i_wr_adder      (r_adder_sh),
      .i_wr_ampl       (r_ampl_sh),
      .o_adder_bus     (adder_bus),
      .o_amplitude_bus (amplitude_bus),
      .o_update_strobe (update_strobe)
   );

   assign frame_error = r_frame_error;
   assign error_code  = r_error_code;
   assign error_count = r_error_count;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frames are driven byte by byte, the
// expected commit/rejection and its cycle are queued and matched by a monitor.
module tb_uart_cmd_parser;

   localparam int          NCH     = 4;
   localparam logic [31:0] RST_VAL = 32'd1000000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       from_uart_data = 8'd0;
   logic             from_uart_valid = 1'b0;
   logic             from_uart_error = 1'b0;
   logic             from_uart_ready;
   logic [NCH*32-1:0] adder_bus;
   logic [NCH*32-1:0] amplitude_bus;
   logic [NCH-1:0]   update_strobe;
   logic             frame_error;
   logic [2:0]       error_code;
   logic [15:0]      error_count;

   uart_cmd_parser #(
      .NUM_CHANNELS   (NCH),
      .ADDER_WIDTH    (32),
      .AMPL_WIDTH     (32),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .from_uart_data  (from_uart_data),
      .from_uart_valid (from_uart_valid),
      .from_uart_error (from_uart_error),
      .from_uart_ready (from_uart_ready),
      .adder_bus       (adder_bus),
      .amplitude_bus   (amplitude_bus),
      .update_strobe   (update_strobe),
      .frame_error     (frame_error),
      .error_code      (error_code),
      .error_count     (error_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_commit;
      logic [7:0]  ch;
      logic [31:0] ad;
      logic [31:0] am;
      logic [2:0]  code;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          ready_low_cnt = 0;
   int          n_commit_exp = 0;
   logic [15:0] m_err_cnt = 16'd0;
   logic [31:0] m_adder[NCH];
   logic [31:0] m_ampl[NCH];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_bank();
      for (int k = 0; k < NCH; k++) begin
         check_val($sformatf("adder_ch%0d", k), adder_bus[k*32 +: 32], m_adder[k]);
         check_val($sformatf("ampl_ch%0d", k), amplitude_bus[k*32 +: 32], m_ampl[k]);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_adder[k] = RST_VAL;
         m_ampl[k]  = RST_VAL;
      end
      m_err_cnt = 16'd0;
   endtask

   task automatic push_evt(input bit c, input logic [7:0] ch, input logic [31:0] ad,
                           input logic [31:0] am, input logic [2:0] code, input int at);
      exp_t e;
      e.is_commit = c;
      e.ch        = ch;
      e.ad        = ad;
      e.am        = am;
      e.code      = code;
      e.cyc       = at;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      from_uart_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns the cycle number of the accepting edge.
   task automatic send_byte(input logic [7:0] b, input logic e, output int acc);
      logic rdy;
      int   n;
      from_uart_data  = b;
      from_uart_valid = 1'b1;
      from_uart_error = e;
      n = 0;
      do begin
         rdy = from_uart_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 50);
      if (!rdy) check_val("accept_bound", 64'd0, 64'd1);
      acc = cyc;
      from_uart_error = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] ch, input logic [31:0] ad, input logic [31:0] am,
                             input logic [7:0] cx, input logic [7:0] eom, input int err_idx,
                             input bit hold);
      logic [7:0] b[12];
      logic [7:0] x;
      int         acc;
      bit         aborted;
      aborted = 1'b0;
      x = ch ^ ad[31:24] ^ ad[23:16] ^ ad[15:8] ^ ad[7:0]
             ^ am[31:24] ^ am[23:16] ^ am[15:8] ^ am[7:0];
      b[0] = 8'd153;     b[1] = ch;
      b[2] = ad[31:24];  b[3] = ad[23:16]; b[4] = ad[15:8]; b[5] = ad[7:0];
      b[6] = am[31:24];  b[7] = am[23:16]; b[8] = am[15:8]; b[9] = am[7:0];
      b[10] = x ^ cx;    b[11] = eom;
      for (int i = 0; i < 12; i++) begin
         send_byte(b[i], (i == err_idx), acc);
         if (i == err_idx && i >= 1) begin
            push_evt(1'b0, ch, 32'd0, 32'd0, 3'd4, acc);
            aborted = 1'b1;
            break;
         end
         if (!hold && i < 11) idle($urandom_range(0, 2));
      end
      if (!aborted) begin
         if (eom != 8'd235)       push_evt(1'b0, ch, ad, am, 3'd1, acc);
         else if (cx != 8'd0)     push_evt(1'b0, ch, ad, am, 3'd2, acc);
         else if (ch >= 8'(NCH))  push_evt(1'b0, ch, ad, am, 3'd3, acc);
         else begin
            push_evt(1'b1, ch, ad, am, 3'd0, acc + 2);
            n_commit_exp++;
         end
      end
      if (!hold) idle(3);
   endtask

   // monitor: every strobe or frame_error must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (!from_uart_ready) ready_low_cnt++;
         if (update_strobe != '0 || frame_error) begin
            if (sb.size() == 0) begin
               check_val("unexpected_event", {59'd0, update_strobe, frame_error}, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check_val("evt_cycle", 64'(cyc), 64'(mon_e.cyc));
               if (mon_e.is_commit) begin
                  check_val("commit_frame_error", 64'(frame_error), 64'd0);
                  check_val("commit_strobe", 64'(update_strobe), 64'd1 << mon_e.ch);
                  m_adder[mon_e.ch[1:0]] = mon_e.ad;
                  m_ampl[mon_e.ch[1:0]]  = mon_e.am;
               end else begin
                  if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
                  check_val("reject_strobe", 64'(update_strobe), 64'd0);
                  check_val("reject_code", 64'(error_code), 64'(mon_e.code));
                  check_val("reject_count", 64'(error_count), 64'(m_err_cnt));
               end
               check_bank();
            end
         end
      end
   end

   initial begin
      int acc;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check_val("rst_ready", 64'(from_uart_ready), 64'd1);
      check_val("rst_strobe", 64'(update_strobe), 64'd0);
      check_val("rst_frame_error", 64'(frame_error), 64'd0);
      check_val("rst_code", 64'(error_code), 64'd0);
      check_val("rst_count", 64'(error_count), 64'd0);
      check_bank();

      // junk, and a SOM carrying a line error, are dropped silently in IDLE
      send_byte(8'h00, 1'b0, acc);
      send_byte(8'hEB, 1'b0, acc);
      send_byte(8'd153, 1'b1, acc);
      idle(3);

      send_frame(8'h01, 32'h000F4240, 32'h00008000, 8'h00, 8'd235, -1, 1'b0);
      check_val("t1_adder_ch1", 64'(adder_bus[63:32]), 64'h000F4240);
      check_val("t1_ampl_ch1", 64'(amplitude_bus[63:32]), 64'h00008000);
      check_val("t1_count", 64'(error_count), 64'd0);

      send_frame(8'h01, 32'h000F4240, 32'h00008000, 8'h01, 8'd235, -1, 1'b0);
      send_frame(8'h07, 32'h12345678, 32'h9ABCDEF0, 8'h00, 8'd235, -1, 1'b0);
      send_frame(8'h02, 32'h11111111, 32'h22222222, 8'h01, 8'hEA, -1, 1'b0);
      check_val("code_held", 64'(error_code), 64'd1);

      send_frame(8'h02, 32'hA5A5A5A5, 32'h5A5A5A5A, 8'h00, 8'd235, 4, 1'b0);
      send_frame(8'h02, 32'hCAFEF00D, 32'h0000BEEF, 8'h00, 8'd235, -1, 1'b0);

      // stall after the channel byte until the timeout fires
      send_byte(8'd153, 1'b0, acc);
      send_byte(8'h03, 1'b0, acc);
      push_evt(1'b0, 8'h03, 32'd0, 32'd0, 3'd5, acc + 99);
      idle(110);

      for (int f = 0; f < 10; f++) begin
         send_frame(8'(f % NCH), $urandom, $urandom, 8'h00, 8'd235, -1, 1'b1);
      end
      idle(5);

      // async reset in the middle of a frame
      send_byte(8'd153, 1'b0, acc);
      send_byte(8'h01, 1'b0, acc);
      send_byte(8'hAA, 1'b0, acc);
      send_byte(8'hBB, 1'b0, acc);
      from_uart_valid = 1'b0;
      #3 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_val("mid_rst_count", 64'(error_count), 64'd0);
      check_val("mid_rst_code", 64'(error_code), 64'd0);
      check_val("mid_rst_ready", 64'(from_uart_ready), 64'd1);
      check_val("mid_rst_sb", 64'(sb.size()), 64'd0);
      check_bank();

      send_frame(8'h03, 32'h0BADC0DE, 32'h00001234, 8'h00, 8'd235, -1, 1'b0);
      idle(10);

      check_val("sb_drained", 64'(sb.size()), 64'd0);
      check_val("ready_low_cycles", 64'(ready_low_cnt), 64'(n_commit_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Parametrised successor of the waveform-generator UART command receiver.
- Consumes the byte stream from the UART RX core and parses framed configuration commands.
- Frame: SOM, channel, phase-adder word, amplitude word, optional XOR checksum, EOM.
- Validated frames commit atomically into a per-channel register bank that drives NUM_CHANNELS DDS channels; malformed frames are dropped, flagged and counted.

Parameters:
- NUM_CHANNELS, 4, number of DDS channels (1..256)
- ADDER_WIDTH, 32, phase-adder word width; multiple of 8, range 8..64
- AMPL_WIDTH, 32, amplitude word width; multiple of 8, range 8..64
- SOM_BYTE, 8'd153, start-of-message marker
- EOM_BYTE, 8'd235, end-of-message marker
- CHECKSUM_EN, 1, 1 = checksum byte present before EOM
- TIMEOUT_CYCLES, 50000, maximum clk cycles between accepted bytes inside a frame
- RESET_ADDER, 32'd1000000, bank reset value of every adder (truncated/zero-extended to ADDER_WIDTH)
- RESET_AMPL, 32'd1000000, bank reset value of every amplitude

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- from_uart_data  in  8  received byte
- from_uart_valid  in  1  byte available
- from_uart_error  in  1  RX line/framing error, qualified by from_uart_valid
- from_uart_ready  out  1  parser accepts a byte this cycle
- adder_bus  out  NUM_CHANNELS*ADDER_WIDTH  channel k at [k*ADDER_WIDTH +: ADDER_WIDTH]
- amplitude_bus  out  NUM_CHANNELS*AMPL_WIDTH  channel k at [k*AMPL_WIDTH +: AMPL_WIDTH]
- update_strobe  out  NUM_CHANNELS  one-cycle pulse on the channel just written
- frame_error  out  1  one-cycle pulse when a frame is rejected
- error_code  out  3  cause of last rejection; held until next rejection
- error_count  out  16  rejected-frame count, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; from_uart_ready=1; update_strobe=0; frame_error=0; error_code=0; error_count=0.
  - All bank entries to RESET_ADDER/RESET_AMPL; shadow registers, byte counter, checksum and timeout counter cleared.
  - Reset mid-frame discards the partial frame without affecting the error counters.
- Handshake: a byte is accepted on any rising edge where from_uart_valid && from_uart_ready. from_uart_ready is 1 in every state except COMMIT.
- States:
  - IDLE: accepted SOM_BYTE -> CHAN; any other byte dropped silently with no error.
  - CHAN: latch channel byte, seed checksum with it -> ADDER.
  - ADDER: ADDER_WIDTH/8 bytes, MSB first, shifted into a shadow register -> AMPL.
  - AMPL: AMPL_WIDTH/8 bytes, MSB first -> CSUM if CHECKSUM_EN, else EOM.
  - CSUM: latch received checksum -> EOM.
  - EOM: evaluate the frame -> COMMIT if good, else IDLE with rejection.
  - COMMIT: one cycle, ready=0. The edge leaving COMMIT writes the bank entry and pulses update_strobe[ch] -> IDLE.
- Latency: new bank value and strobe are visible 2 cycles after the EOM acceptance edge.
- Checksum: running XOR of the channel byte and all adder/amplitude bytes. Must equal the CSUM byte.
- Live bank registers are never modified by a partial or rejected frame (shadow registers only).
- Rejection checks at EOM, priority order:
  - 1 = EOM byte mismatch
  - 2 = checksum mismatch
  - 3 = channel >= NUM_CHANNELS
- Mid-frame aborts:
  - 4 = from_uart_error on any accepted beat in CHAN..EOM; abort immediately -> IDLE. In IDLE this beat is dropped with no error.
  - 5 = timeout: counter resets on each accepted byte and runs only in CHAN..EOM. Reaching TIMEOUT_CYCLES-1 -> IDLE.
- Rejection effect: frame_error pulses one cycle, error_code updates, error_count increments (saturating).
- SOM inside a frame is ordinary payload, with no resync; resync occurs only via IDLE.
- Back-to-back frames: a SOM arriving during COMMIT is stalled one cycle, not lost.

Decomposition:
- Package uart_cmd_pkg holds:
  - FSM state encoding
  - error code constants (ERR_NONE, ERR_EOM, ERR_CSUM, ERR_CHAN, ERR_LINE, ERR_TIMEOUT)
  - default SOM/EOM values
- Sub-module uart_cmd_bank: NUM_CHANNELS register bank with reset values, write-enable + channel index + data inputs, flattened bus outputs and update_strobe generation.

Test Plan:
- Single good frame, CHECKSUM_EN=1, defaults. Bytes 153,01,00,0F,42,40,00,00,80,00,8C,235 -> update_strobe=4'b0010 once; channel 1 adder=32'h000F4240, amplitude=32'h00008000; other channels remain 1000000; error_count=0.
- Same frame with checksum 8D -> frame_error pulse, error_code=2, error_count=1; bank unchanged.
- Channel byte 07 with NUM_CHANNELS=4 and correct checksum -> error_code=3; no strobe.
- Last byte 0xEA instead of 235, with the checksum also corrupted -> error_code=1 (priority over checksum).
- Abort cases:
  - from_uart_error asserted on the third adder byte -> error_code=4; the immediately following good frame commits normally.
  - TIMEOUT_CYCLES=100, stall after the channel byte -> error_code=5 at cycle 99 of the gap.
- Ten back-to-back good frames with from_uart_valid held high on channels 0..3 -> all commit, ready low exactly one cycle per frame. Async rst asserted mid-frame then released -> bank at reset values, next frame accepted.
